// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, address/colour types and scheduler enums for the
// framebuffer write-port scheduler.
package fb_pkg;

   localparam int unsigned FB_X_W    = 10;
   localparam int unsigned FB_Y_W    = 9;
   localparam int unsigned FB_DATA_W = 3;
   localparam int unsigned FB_X_MAX  = 639;
   localparam int unsigned FB_Y_MAX  = 479;

   typedef struct packed {
      logic [FB_X_W-1:0] x;
      logic [FB_Y_W-1:0] y;
   } fb_addr_t;

   typedef logic [FB_DATA_W-1:0] fb_color_t;

   typedef enum logic {ARB, CLEAR} sched_state_t;

   typedef enum logic {SRC_TRACE, SRC_CUR} sched_src_t;

endpackage

// File: rtl/fb_clear_sweep.sv
// Full-screen clear engine: sweeps {x,y} with y as the inner index and strobes one write
// per cycle with the colour captured at start.
module fb_clear_sweep
   import fb_pkg::*;
#(
   parameter int unsigned X_W    = FB_X_W,
   parameter int unsigned Y_W    = FB_Y_W,
   parameter int unsigned DATA_W = FB_DATA_W,
   parameter int unsigned X_MAX  = FB_X_MAX,
   parameter int unsigned Y_MAX  = FB_Y_MAX
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_color,
   output logic [X_W-1:0]    o_x,
   output logic [Y_W-1:0]    o_y,
   output logic [DATA_W-1:0] o_color,
   output logic              o_we,
   output logic              o_last
);

   localparam logic [X_W-1:0] XLast = X_W'(X_MAX);
   localparam logic [Y_W-1:0] YLast = Y_W'(Y_MAX);

   logic              active_q;
   logic [X_W-1:0]    x_q;
   logic [Y_W-1:0]    y_q;
   logic [DATA_W-1:0] color_q;

   assign o_last = active_q && (x_q == XLast) && (y_q == YLast);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         active_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         color_q  <= '0;
      end else if (i_start) begin
         active_q <= 1'b1;
         x_q      <= '0;
         y_q      <= '0;
         color_q  <= i_color;
      end else if (active_q) begin
         if (o_last) begin
            active_q <= 1'b0;
         end else if (y_q == YLast) begin
            y_q <= '0;
            x_q <= x_q + 1'b1;
         end else begin
            y_q <= y_q + 1'b1;
         end
      end
   end

   assign o_x     = x_q;
   assign o_y     = y_q;
   assign o_color = color_q;
   assign o_we    = active_q;

endmodule

// File: rtl/fb_write_sched.sv
// Arbitrates the framebuffer RAM write port between the clear engine, the trace plotter
// and the cursor sketch path; round-robin between trace and cursor.
module fb_write_sched
   import fb_pkg::*;
#(
   parameter int unsigned X_W    = FB_X_W,
   parameter int unsigned Y_W    = FB_Y_W,
   parameter int unsigned DATA_W = FB_DATA_W,
   parameter int unsigned X_MAX  = FB_X_MAX,
   parameter int unsigned Y_MAX  = FB_Y_MAX
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clear_req,
   input  logic [DATA_W-1:0]    i_clear_color,
   input  logic                 i_trace_valid,
   input  logic [X_W-1:0]       i_trace_x,
   input  logic [Y_W-1:0]       i_trace_y,
   input  logic [DATA_W-1:0]    i_trace_color,
   output logic                 o_trace_ready,
   input  logic                 i_cur_valid,
   input  logic [X_W-1:0]       i_cur_x,
   input  logic [Y_W-1:0]       i_cur_y,
   input  logic [DATA_W-1:0]    i_cur_color,
   output logic                 o_cur_ready,
   output logic                 o_we,
   output logic [X_W+Y_W-1:0]   o_addr,
   output logic [DATA_W-1:0]    o_data,
   output logic                 o_busy,
   output logic                 o_clear_done,
   output logic [7:0]           o_drop_count
);

   localparam logic [X_W-1:0] XLast = X_W'(X_MAX);
   localparam logic [Y_W-1:0] YLast = Y_W'(Y_MAX);

   sched_state_t          state_q, state_d;
   sched_src_t            last_q, last_d;
   logic                  we_q, we_d;
   logic [X_W+Y_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic                  done_q, done_d;
   logic [7:0]            drop_q, drop_d;

   logic                  sw_start, sw_we, sw_last;
   logic [X_W-1:0]        sw_x;
   logic [Y_W-1:0]        sw_y;
   logic [DATA_W-1:0]     sw_color;

   logic                  grant_tr, grant_cu;
   logic [X_W-1:0]        sel_x;
   logic [Y_W-1:0]        sel_y;
   logic [DATA_W-1:0]     sel_color;

   fb_clear_sweep #(
      .X_W    (X_W),
      .Y_W    (Y_W),
      .DATA_W (DATA_W),
      .X_MAX  (X_MAX),
      .Y_MAX  (Y_MAX)
   ) u_sweep (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (sw_start),
      .i_color (i_clear_color),
      .o_x     (sw_x),
      .o_y     (sw_y),
      .o_color (sw_color),
      .o_we    (sw_we),
      .o_last  (sw_last)
   );

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      done_d    = 1'b0;
      drop_d    = drop_q;
      sw_start  = 1'b0;
      grant_tr  = 1'b0;
      grant_cu  = 1'b0;
      sel_x     = i_trace_x;
      sel_y     = i_trace_y;
      sel_color = i_trace_color;

      unique case (state_q)
         ARB: begin
            if (i_clear_req) begin
               state_d  = CLEAR;
               sw_start = 1'b1;
            end else begin
               grant_tr = i_trace_valid && (!i_cur_valid || (last_q == SRC_CUR));
               grant_cu = i_cur_valid && !grant_tr;
               if (grant_cu) begin
                  sel_x     = i_cur_x;
                  sel_y     = i_cur_y;
                  sel_color = i_cur_color;
               end
               if (grant_tr || grant_cu) begin
                  last_d = grant_cu ? SRC_CUR : SRC_TRACE;
                  if ((sel_x <= XLast) && (sel_y <= YLast)) begin
                     we_d   = 1'b1;
                     addr_d = {sel_x, sel_y};
                     data_d = sel_color;
                  end else if (drop_q != 8'hff) begin
                     drop_d = drop_q + 8'd1;
                  end
               end
            end
         end
         CLEAR: begin
            // Latch the final clear write so o_addr/o_data hold it once the sweep stops.
            if (sw_last) begin
               state_d = ARB;
               done_d  = 1'b1;
               addr_d  = {sw_x, sw_y};
               data_d  = sw_color;
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ARB;
         last_q  <= SRC_CUR;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
      end
   end

   assign o_trace_ready = grant_tr;
   assign o_cur_ready   = grant_cu;
   assign o_we          = sw_we | we_q;
   assign o_addr        = sw_we ? {sw_x, sw_y} : addr_q;
   assign o_data        = sw_we ? sw_color : data_q;
   assign o_busy        = (state_q == CLEAR);
   assign o_clear_done  = done_q;
   assign o_drop_count  = drop_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Self-checking bench for fb_write_sched; the screen is shrunk to 64x48 so full clears
// stay short, while coordinate widths keep their framebuffer sizes.
module tb_fb_write_sched;

   localparam int unsigned XW   = 10;
   localparam int unsigned YW   = 9;
   localparam int unsigned DW   = 3;
   localparam int unsigned XM   = 63;
   localparam int unsigned YM   = 47;
   localparam int          NCLR = (XM + 1) * (YM + 1);

   logic           clk = 1'b0;
   logic           rst;
   logic           clr_req;
   logic [DW-1:0]  clr_color;
   logic           tr_valid, tr_ready;
   logic [XW-1:0]  tr_x;
   logic [YW-1:0]  tr_y;
   logic [DW-1:0]  tr_color;
   logic           cu_valid, cu_ready;
   logic [XW-1:0]  cu_x;
   logic [YW-1:0]  cu_y;
   logic [DW-1:0]  cu_color;
   logic           we, busy, done;
   logic [XW+YW-1:0] addr;
   logic [DW-1:0]  data;
   logic [7:0]     drop;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: arbitration pointer, expected write-port registers, drop count.
   logic             m_last_cur;
   int unsigned      m_drop;
   logic             m_we;
   logic [XW+YW-1:0] m_addr;
   logic [DW-1:0]    m_data;

   always #5 clk = ~clk;

   fb_write_sched #(
      .X_W    (XW),
      .Y_W    (YW),
      .DATA_W (DW),
      .X_MAX  (XM),
      .Y_MAX  (YM)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_clear_req   (clr_req),
      .i_clear_color (clr_color),
      .i_trace_valid (tr_valid),
      .i_trace_x     (tr_x),
      .i_trace_y     (tr_y),
      .i_trace_color (tr_color),
      .o_trace_ready (tr_ready),
      .i_cur_valid   (cu_valid),
      .i_cur_x       (cu_x),
      .i_cur_y       (cu_y),
      .i_cur_color   (cu_color),
      .o_cur_ready   (cu_ready),
      .o_we          (we),
      .o_addr        (addr),
      .o_data        (data),
      .o_busy        (busy),
      .o_clear_done  (done),
      .o_drop_count  (drop)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clr_req  = 1'b0;
      tr_valid = 1'b0;
      cu_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic logic [XW+YW-1:0] sweep_addr(input int k);
      return {XW'(k / (YM + 1)), YW'(k % (YM + 1))};
   endfunction

   task automatic test_reset();
      tr_x = '0; tr_y = '0; tr_color = '0; cu_x = '0; cu_y = '0; cu_color = '0;
      clr_color = '0;
      do_reset();
      #1;
      n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", we); end
      n_cmp++; if (addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", addr); end
      n_cmp++; if (data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", data); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (drop !== 8'd0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop); end
   endtask

   task automatic test_single_trace();
      tr_valid = 1'b1; tr_x = 10'd10; tr_y = 9'd20; tr_color = 3'b101;
      #1;
      n_cmp++;
      if ({tr_ready, cu_ready} !== 2'b10) begin
         n_bad++; $display("FAIL single_ready: got %b want 10", {tr_ready, cu_ready});
      end
      tick(); idle(); #1;
      n_cmp++;
      if (we !== 1'b1 || addr !== {10'd10, 9'd20} || data !== 3'd5) begin
         n_bad++; $display("FAIL single_write: got we=%b addr=%h data=%0d want we=1 addr=%h data=5",
                           we, addr, data, {10'd10, 9'd20});
      end
      tick(); #1;
      n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL single_we_off: got %b want 0", we); end
   endtask

   task automatic test_round_robin();
      logic [1:0]       exp_rdy;
      logic [XW+YW-1:0] exp_addr;
      do_reset();
      tr_valid = 1'b1; tr_x = 10'd1; tr_y = 9'd2; tr_color = 3'd1;
      cu_valid = 1'b1; cu_x = 10'd3; cu_y = 9'd4; cu_color = 3'd2;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) idle();
         #1;
         if (i < 4) begin
            exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
            n_cmp++;
            if ({tr_ready, cu_ready} !== exp_rdy) begin
               n_bad++; $display("FAIL rr_grant%0d: got %b want %b", i, {tr_ready, cu_ready}, exp_rdy);
            end
         end
         if (i > 0) begin
            exp_addr = ((i - 1) % 2 == 0) ? {10'd1, 9'd2} : {10'd3, 9'd4};
            n_cmp++;
            if (we !== 1'b1 || addr !== exp_addr) begin
               n_bad++; $display("FAIL rr_write%0d: got we=%b addr=%h want we=1 addr=%h",
                                 i, we, addr, exp_addr);
            end
         end
         tick();
      end
   endtask

   task automatic test_drop();
      int bad = 0;
      do_reset();
      cu_valid = 1'b1; cu_x = 10'd640; cu_y = 9'd5; cu_color = 3'd7;
      #1;
      n_cmp++; if (cu_ready !== 1'b1) begin n_bad++; $display("FAIL drop_ready: got %b want 1", cu_ready); end
      tick(); idle(); #1;
      n_cmp++;
      if (we !== 1'b0 || drop !== 8'd1) begin
         n_bad++; $display("FAIL drop_first: got we=%b drop=%0d want we=0 drop=1", we, drop);
      end
      for (int i = 0; i < 300; i++) begin
         cu_valid = 1'b1;
         if ($urandom_range(0, 1) == 1) begin
            cu_x = XW'($urandom_range(XM + 1, 1023)); cu_y = YW'($urandom_range(0, 511));
         end else begin
            cu_x = XW'($urandom_range(0, 1023)); cu_y = YW'($urandom_range(YM + 1, 511));
         end
         #1;
         if (cu_ready !== 1'b1 || we !== 1'b0) bad++;
         tick();
      end
      idle(); #1;
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL drop_accept_nowrite: got %0d bad cycles want 0", bad); end
      n_cmp++; if (drop !== 8'd255) begin n_bad++; $display("FAIL drop_saturate: got %0d want 255", drop); end
   endtask

   task automatic test_random();
      logic et, ec;
      int unsigned x, y;
      do_reset();
      m_last_cur = 1'b1; m_drop = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
      for (int i = 0; i < 400; i++) begin
         tr_valid = 1'($urandom_range(0, 1));
         cu_valid = 1'($urandom_range(0, 1));
         tr_x = ($urandom_range(0, 5) == 0) ? XW'($urandom_range(XM + 1, 1023))
                                            : XW'($urandom_range(0, XM));
         tr_y = YW'($urandom_range(0, YM));
         cu_x = XW'($urandom_range(0, XM));
         cu_y = ($urandom_range(0, 5) == 0) ? YW'($urandom_range(YM + 1, 511))
                                            : YW'($urandom_range(0, YM));
         tr_color = DW'($urandom_range(0, 7));
         cu_color = DW'($urandom_range(0, 7));
         #1;
         // A lone requester always wins; on a tie the side not served last wins.
         et = tr_valid && (!cu_valid || m_last_cur);
         ec = cu_valid && (!tr_valid || !m_last_cur);
         n_cmp++;
         if ({tr_ready, cu_ready} !== {et, ec}) begin
            n_bad++; $display("FAIL rand_ready%0d: got %b want %b", i, {tr_ready, cu_ready}, {et, ec});
         end
         n_cmp++;
         if (we !== m_we || addr !== m_addr || data !== m_data || drop !== 8'(m_drop)) begin
            n_bad++; $display("FAIL rand_port%0d: got we=%b a=%h d=%0d drop=%0d want we=%b a=%h d=%0d drop=%0d",
                              i, we, addr, data, drop, m_we, m_addr, m_data, m_drop);
         end
         m_we = 1'b0;
         if (et || ec) begin
            m_last_cur = ec;
            x = et ? 32'(tr_x) : 32'(cu_x);
            y = et ? 32'(tr_y) : 32'(cu_y);
            if (x <= XM && y <= YM) begin
               m_we = 1'b1; m_addr = {XW'(x), YW'(y)}; m_data = et ? tr_color : cu_color;
            end else if (m_drop < 255) begin
               m_drop++;
            end
         end
         tick();
      end
      idle();
   endtask

   task automatic test_clear();
      int busy_bad = 0, addr_bad = 0, data_bad = 0, done_bad = 0;
      do_reset();
      clr_req = 1'b1; clr_color = 3'b010;
      tick();
      clr_req = 1'b0; clr_color = 3'b111;
      for (int k = 0; k < NCLR; k++) begin
         #1;
         if (busy !== 1'b1) busy_bad++;
         if (we !== 1'b1 || addr !== sweep_addr(k)) begin
            if (addr_bad == 0) $display("first bad sweep index %0d: addr=%h expected=%h", k, addr, sweep_addr(k));
            addr_bad++;
         end
         if (data !== 3'b010) data_bad++;
         if (done !== 1'b0) done_bad++;
         tick();
      end
      #1;
      n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL clear_busy: got %0d idle cycles want 0", busy_bad); end
      n_cmp++; if (addr_bad != 0) begin n_bad++; $display("FAIL clear_sweep: got %0d bad writes want 0", addr_bad); end
      n_cmp++; if (data_bad != 0) begin n_bad++; $display("FAIL clear_color: got %0d bad data want 0", data_bad); end
      n_cmp++; if (done_bad != 0) begin n_bad++; $display("FAIL clear_early_done: got %0d want 0", done_bad); end
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b1 || we !== 1'b0) begin
         n_bad++; $display("FAIL clear_end: got busy=%b done=%b we=%b want 0 1 0", busy, done, we);
      end
      n_cmp++;
      if (addr !== {XW'(XM), YW'(YM)} || data !== 3'b010) begin
         n_bad++; $display("FAIL clear_hold: got addr=%h data=%0d want %h 2", addr, data, {XW'(XM), YW'(YM)});
      end
      tick(); #1;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL clear_done_pulse: got %b want 0", done); end
   endtask

   task automatic test_clear_stall();
      int stall_bad = 0, sweep_bad = 0;
      tr_valid = 1'b1; tr_x = 10'd7; tr_y = 9'd8; tr_color = 3'd6;
      clr_req = 1'b1; clr_color = 3'b100;
      #1;
      n_cmp++; if (tr_ready !== 1'b0) begin n_bad++; $display("FAIL stall_req_cycle: got %b want 0", tr_ready); end
      tick();
      for (int k = 0; k < NCLR; k++) begin
         clr_req = (k == NCLR / 2);
         #1;
         if (tr_ready !== 1'b0) stall_bad++;
         if (busy !== 1'b1 || we !== 1'b1 || addr !== sweep_addr(k) || data !== 3'b100) sweep_bad++;
         tick();
      end
      clr_req = 1'b0;
      #1;
      n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL stall_ready: got %0d ready cycles want 0", stall_bad); end
      n_cmp++; if (sweep_bad != 0) begin n_bad++; $display("FAIL stall_no_restart: got %0d bad writes want 0", sweep_bad); end
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b1 || tr_ready !== 1'b1) begin
         n_bad++; $display("FAIL stall_release: got busy=%b done=%b ready=%b want 0 1 1", busy, done, tr_ready);
      end
      tick(); idle(); #1;
      n_cmp++;
      if (we !== 1'b1 || addr !== {10'd7, 9'd8} || data !== 3'd6) begin
         n_bad++; $display("FAIL stall_write: got we=%b addr=%h data=%0d want 1 %h 6", we, addr, data, {10'd7, 9'd8});
      end
   endtask

   task automatic test_reset_mid_clear();
      int bad = 0;
      tick();
      clr_req = 1'b1; clr_color = 3'b111;
      tick();
      clr_req = 1'b0;
      for (int k = 0; k < 1000; k++) tick();
      #1;
      n_cmp++;
      if (we !== 1'b1 || addr !== sweep_addr(1000)) begin
         n_bad++; $display("FAIL rstclr_pre: got we=%b addr=%h want 1 %h", we, addr, sweep_addr(1000));
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (we !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL rstclr_abort: got we=%b busy=%b want 0 0", we, busy);
      end
      for (int k = 0; k < 20; k++) begin
         tick();
         if (we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
      end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rstclr_quiet: got %0d active cycles want 0", bad); end
      tr_valid = 1'b1; tr_x = 10'd3; tr_y = 9'd4; tr_color = 3'd1;
      #1;
      n_cmp++; if (tr_ready !== 1'b1) begin n_bad++; $display("FAIL rstclr_ready: got %b want 1", tr_ready); end
      tick(); idle(); #1;
      n_cmp++;
      if (we !== 1'b1 || addr !== {10'd3, 9'd4} || data !== 3'd1) begin
         n_bad++; $display("FAIL rstclr_write: got we=%b addr=%h data=%0d want 1 %h 1", we, addr, data, {10'd3, 9'd4});
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_single_trace();
      test_round_robin();
      test_drop();
      test_random();
      test_clear();
      test_clear_stall();
      test_reset_mid_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
